// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the 3-stage pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

  localparam int REG_ADDR_W = 3;
  localparam int DATA_W     = 10;
  localparam logic [DATA_W-1:0] NOP_INSTR = 10'h000;

  typedef enum logic [2:0] {
    ST_BOOT    = 3'd0,
    ST_RUN     = 3'd1,
    ST_LDSTALL = 3'd2,
    ST_MEMWAIT = 3'd3,
    ST_HALT    = 3'd4
  } state_e;

  typedef struct packed {
    logic pc_we;
    logic ifid_we;
    logic ifid_flush;
    logic idex_bubble;
    logic exwb_we;
  } pipe_ctl_t;

  localparam pipe_ctl_t CTL_RUN    = 5'b11001;
  localparam pipe_ctl_t CTL_FREEZE = 5'b00000;
  localparam pipe_ctl_t CTL_BOOT   = 5'b00110;
  localparam pipe_ctl_t CTL_HLTRET = 5'b00111;
  localparam pipe_ctl_t CTL_BRANCH = 5'b11111;
  localparam pipe_ctl_t CTL_STALL  = 5'b00011;

  // True when a decode operand that is actually read names the given register.
  function automatic logic reads_reg(input logic uses, input logic [REG_ADDR_W-1:0] src,
                                     input logic [REG_ADDR_W-1:0] dest);
    return uses & (src == dest);
  endfunction

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard compare between the decode operands and the load in execute.
module hazard_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int ZERO_REG_HW = 1
) (
  input  logic [REG_ADDR_W-1:0] id_src_a_i,
  input  logic [REG_ADDR_W-1:0] id_src_b_i,
  input  logic                  id_uses_a_i,
  input  logic                  id_uses_b_i,
  input  logic [REG_ADDR_W-1:0] ex_dest_reg_i,
  input  logic                  ex_reg_wr_i,
  input  logic                  ex_is_load_i,
  output logic                  hazard_o
);

  logic dest_is_r0_s;
  logic dep_s;

  assign dest_is_r0_s = (ZERO_REG_HW != 0) && (ex_dest_reg_i == 3'd0);
  assign dep_s = reads_reg(id_uses_a_i, id_src_a_i, ex_dest_reg_i)
               | reads_reg(id_uses_b_i, id_src_b_i, ex_dest_reg_i);
  assign hazard_o = ex_is_load_i & ex_reg_wr_i & ~dest_is_r0_s & dep_s;

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer: drives pipeline-register enables, bubbles and flushes.
// Optional build macro PIPE_PERF_CNT_EN adds stall/flush performance counters.
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int LD_STALL_CYCLES = 1,
  parameter int MEM_TIMEOUT     = 0,
  parameter int ZERO_REG_HW     = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] id_src_a,
  input  logic [2:0] id_src_b,
  input  logic       id_uses_a,
  input  logic       id_uses_b,
  input  logic [2:0] ex_dest_reg,
  input  logic       ex_reg_wr,
  input  logic       ex_is_load,
  input  logic       ex_branch_tkn,
  input  logic       mem_req,
  input  logic       mem_ready,
  input  logic       halt_req,
  output logic       pc_we,
  output logic       ifid_we,
  output logic       ifid_flush,
  output logic       idex_bubble,
  output logic       exwb_we,
  output logic       halted,
  output logic       mem_err
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [15:0] stall_cycles,
  output logic [15:0] flush_count
`endif
);

  state_e     state_q, state_d;
  logic [2:0] stall_cnt_q, stall_cnt_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       ret_ld_q, ret_ld_d;
  logic       mem_err_q, mem_err_d;
  pipe_ctl_t  ctl_s;
  logic       halted_s;
  logic       flush_evt_s;
  logic       hazard_s;
  logic       mem_stall_s;

  hazard_detect #(.ZERO_REG_HW(ZERO_REG_HW)) u_hazard (
    .id_src_a_i   (id_src_a),
    .id_src_b_i   (id_src_b),
    .id_uses_a_i  (id_uses_a),
    .id_uses_b_i  (id_uses_b),
    .ex_dest_reg_i(ex_dest_reg),
    .ex_reg_wr_i  (ex_reg_wr),
    .ex_is_load_i (ex_is_load),
    .hazard_o     (hazard_s)
  );

  assign mem_stall_s = mem_req & ~mem_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_BOOT;
      stall_cnt_q <= 3'd0;
      wait_cnt_q  <= 8'd0;
      ret_ld_q    <= 1'b0;
      mem_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      ret_ld_q    <= ret_ld_d;
      mem_err_q   <= mem_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    stall_cnt_d = stall_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    ret_ld_d    = ret_ld_q;
    mem_err_d   = mem_err_q;
    ctl_s       = CTL_RUN;
    halted_s    = 1'b0;
    flush_evt_s = 1'b0;
    case (state_q)
      ST_BOOT: begin
        ctl_s   = CTL_BOOT;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (mem_stall_s) begin
          ctl_s      = CTL_FREEZE;
          state_d    = ST_MEMWAIT;
          wait_cnt_d = 8'd1;
          ret_ld_d   = 1'b0;
        end else if (halt_req) begin
          ctl_s   = CTL_HLTRET;
          state_d = ST_HALT;
        end else if (ex_branch_tkn) begin
          // The dependent instruction of any hazard is wrong-path, so branch wins.
          ctl_s       = CTL_BRANCH;
          flush_evt_s = 1'b1;
          state_d     = ST_RUN;
        end else if (hazard_s) begin
          ctl_s = CTL_STALL;
          if (LD_STALL_CYCLES > 1) begin
            state_d     = ST_LDSTALL;
            stall_cnt_d = 3'(LD_STALL_CYCLES - 1);
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_LDSTALL: begin
        if (mem_stall_s) begin
          ctl_s      = CTL_FREEZE;
          state_d    = ST_MEMWAIT;
          wait_cnt_d = 8'd1;
          ret_ld_d   = 1'b1;
        end else begin
          ctl_s       = CTL_STALL;
          stall_cnt_d = stall_cnt_q - 3'd1;
          if (stall_cnt_q == 3'd1) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_LDSTALL;
          end
        end
      end
      ST_MEMWAIT: begin
        ctl_s = CTL_FREEZE;
        if (mem_ready) begin
          ctl_s   = CTL_RUN;
          state_d = ret_ld_q ? ST_LDSTALL : ST_RUN;
        end else begin
          if (wait_cnt_q != 8'hFF) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
          end else begin
            wait_cnt_d = wait_cnt_q;
          end
          if ((MEM_TIMEOUT != 0) && (wait_cnt_q == 8'(MEM_TIMEOUT))) begin
            mem_err_d = 1'b1;
            state_d   = ST_HALT;
          end else begin
            state_d = ST_MEMWAIT;
          end
        end
      end
      ST_HALT: begin
        ctl_s    = CTL_FREEZE;
        halted_s = 1'b1;
        state_d  = ST_HALT;
      end
      default: begin
        ctl_s   = CTL_BOOT;
        state_d = ST_BOOT;
      end
    endcase
  end

  assign pc_we       = ctl_s.pc_we;
  assign ifid_we     = ctl_s.ifid_we;
  assign ifid_flush  = ctl_s.ifid_flush;
  assign idex_bubble = ctl_s.idex_bubble;
  assign exwb_we     = ctl_s.exwb_we;
  assign halted      = halted_s;
  assign mem_err     = mem_err_q;

`ifdef PIPE_PERF_CNT_EN
  logic [15:0] stall_cycles_q;
  logic [15:0] flush_count_q;

  // Saturating counts of PC-frozen cycles in live states and of branch flushes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_q <= 16'd0;
      flush_count_q  <= 16'd0;
    end else begin
      if (!ctl_s.pc_we && (state_q != ST_BOOT) && (state_q != ST_HALT)
          && (stall_cycles_q != 16'hFFFF)) begin
        stall_cycles_q <= stall_cycles_q + 16'd1;
      end
      if (flush_evt_s && (flush_count_q != 16'hFFFF)) begin
        flush_count_q <= flush_count_q + 16'd1;
      end
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench: two instances (default params; 3-cycle load stall with 8-cycle mem timeout).
module tb_pipeline_ctrl;

  // Output vector order: pc_we, ifid_we, ifid_flush, idex_bubble, exwb_we, halted, mem_err
  localparam logic [6:0] E_BOOT = 7'b0011000;
  localparam logic [6:0] E_RUN  = 7'b1100100;
  localparam logic [6:0] E_FRZ  = 7'b0000000;
  localparam logic [6:0] E_BR   = 7'b1111100;
  localparam logic [6:0] E_STL  = 7'b0001100;
  localparam logic [6:0] E_HREQ = 7'b0011100;
  localparam logic [6:0] E_HLT  = 7'b0000010;
  localparam logic [6:0] E_HERR = 7'b0000011;

  logic clk = 1'b0;
  logic rst_n;
  logic [2:0] src_a, src_b, dest;
  logic uses_a, uses_b, reg_wr, is_load, br, mreq, mrdy, hreq;
  logic o1_pc, o1_ifid, o1_fl, o1_bub, o1_wb, o1_hlt, o1_err;
  logic o2_pc, o2_ifid, o2_fl, o2_bub, o2_wb, o2_hlt, o2_err;
`ifdef PIPE_PERF_CNT_EN
  logic [15:0] o1_stc, o1_flc, o2_stc, o2_flc;
`endif

  int n_vec = 0;
  int n_err = 0;
  int step  = 0;
  logic [13:0] sb_q[$];

  always #5 clk = ~clk;

  pipeline_ctrl dut1 (
    .clk(clk), .rst_n(rst_n), .id_src_a(src_a), .id_src_b(src_b),
    .id_uses_a(uses_a), .id_uses_b(uses_b), .ex_dest_reg(dest), .ex_reg_wr(reg_wr),
    .ex_is_load(is_load), .ex_branch_tkn(br), .mem_req(mreq), .mem_ready(mrdy),
    .halt_req(hreq), .pc_we(o1_pc), .ifid_we(o1_ifid), .ifid_flush(o1_fl),
    .idex_bubble(o1_bub), .exwb_we(o1_wb), .halted(o1_hlt), .mem_err(o1_err)
`ifdef PIPE_PERF_CNT_EN
    , .stall_cycles(o1_stc), .flush_count(o1_flc)
`endif
  );

  pipeline_ctrl #(.LD_STALL_CYCLES(3), .MEM_TIMEOUT(8), .ZERO_REG_HW(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .id_src_a(src_a), .id_src_b(src_b),
    .id_uses_a(uses_a), .id_uses_b(uses_b), .ex_dest_reg(dest), .ex_reg_wr(reg_wr),
    .ex_is_load(is_load), .ex_branch_tkn(br), .mem_req(mreq), .mem_ready(mrdy),
    .halt_req(hreq), .pc_we(o2_pc), .ifid_we(o2_ifid), .ifid_flush(o2_fl),
    .idex_bubble(o2_bub), .exwb_we(o2_wb), .halted(o2_hlt), .mem_err(o2_err)
`ifdef PIPE_PERF_CNT_EN
    , .stall_cycles(o2_stc), .flush_count(o2_flc)
`endif
  );

  task automatic chk_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    src_a = 3'd0; src_b = 3'd0; dest = 3'd0;
    uses_a = 1'b0; uses_b = 1'b0; reg_wr = 1'b0; is_load = 1'b0;
    br = 1'b0; mreq = 1'b0; mrdy = 1'b0; hreq = 1'b0;
  endtask

  task automatic hazard_a(input logic [2:0] r);
    idle();
    is_load = 1'b1; reg_wr = 1'b1; dest = r; src_a = r; uses_a = 1'b1;
  endtask

  task automatic cyc(input logic [6:0] e1, input logic [6:0] e2);
    sb_q.push_back({e1, e2});
    @(posedge clk);
    #1;
  endtask

  // Pop the expectation queued for this cycle and compare both instances mid-cycle.
  always @(negedge clk) begin
    logic [13:0] v;
    if (sb_q.size() > 0) begin
      v = sb_q.pop_front();
      chk_eq($sformatf("s%0d_dut1", step),
             {9'd0, o1_pc, o1_ifid, o1_fl, o1_bub, o1_wb, o1_hlt, o1_err}, {9'd0, v[13:7]});
      chk_eq($sformatf("s%0d_dut2", step),
             {9'd0, o2_pc, o2_ifid, o2_fl, o2_bub, o2_wb, o2_hlt, o2_err}, {9'd0, v[6:0]});
      step++;
    end
  end

  initial begin
    rst_n = 1'b0;
    idle();
    @(posedge clk); #1;
    cyc(E_BOOT, E_BOOT);
    rst_n = 1'b1;
    cyc(E_BOOT, E_BOOT);
    cyc(E_RUN, E_RUN);

    // Near-miss patterns that must not stall
    hazard_a(3'd3); uses_a = 1'b0; src_b = 3'd1; uses_b = 1'b1;
    cyc(E_RUN, E_RUN);
    hazard_a(3'd3); is_load = 1'b0;
    cyc(E_RUN, E_RUN);
    hazard_a(3'd0);
    cyc(E_RUN, E_RUN);

    // Load-use on src A, then on src B
    hazard_a(3'd3);
    cyc(E_STL, E_STL);
    idle();
    cyc(E_RUN, E_STL); cyc(E_RUN, E_STL); cyc(E_RUN, E_RUN);
    idle(); is_load = 1'b1; reg_wr = 1'b1; dest = 3'd6; src_b = 3'd6; uses_b = 1'b1;
    cyc(E_STL, E_STL);
    idle();
    cyc(E_RUN, E_STL); cyc(E_RUN, E_STL); cyc(E_RUN, E_RUN);

    // Branch beats hazard
    hazard_a(3'd5); br = 1'b1;
    cyc(E_BR, E_BR);
    idle();
    cyc(E_RUN, E_RUN);

    // Memory wait of 4 cycles; branch/halt ignored while frozen
    mreq = 1'b1;
    cyc(E_FRZ, E_FRZ); cyc(E_FRZ, E_FRZ);
    br = 1'b1; hreq = 1'b1;
    cyc(E_FRZ, E_FRZ);
    br = 1'b0; hreq = 1'b0;
    cyc(E_FRZ, E_FRZ);
    mrdy = 1'b1;
    cyc(E_RUN, E_RUN);
    idle();
    cyc(E_RUN, E_RUN);

    // Memory wait interrupting a multi-cycle load stall
    hazard_a(3'd2);
    cyc(E_STL, E_STL);
    idle(); mreq = 1'b1;
    cyc(E_FRZ, E_FRZ);
    mrdy = 1'b1;
    cyc(E_RUN, E_RUN);
    idle();
    cyc(E_RUN, E_STL); cyc(E_RUN, E_STL); cyc(E_RUN, E_RUN);

    // Timeout on dut2 (never on dut1), then halt on dut1
    mreq = 1'b1;
    cyc(E_FRZ, E_FRZ);
    for (int i = 0; i < 8; i++) cyc(E_FRZ, E_FRZ);
    cyc(E_FRZ, E_HERR); cyc(E_FRZ, E_HERR);
    mrdy = 1'b1;
    cyc(E_RUN, E_HERR);
    idle(); hreq = 1'b1;
    cyc(E_HREQ, E_HERR);
    hreq = 1'b0; br = 1'b1;
    cyc(E_HLT, E_HERR);
    idle();
    cyc(E_HLT, E_HERR);

    // Reset out of HALT clears the sticky error
    rst_n = 1'b0;
    cyc(E_BOOT, E_BOOT);
    rst_n = 1'b1;
    cyc(E_BOOT, E_BOOT);
    cyc(E_RUN, E_RUN);

    // Three branch flushes and two load-use stalls
    idle(); br = 1'b1;
    cyc(E_BR, E_BR); cyc(E_BR, E_BR); cyc(E_BR, E_BR);
    for (int k = 0; k < 2; k++) begin
      hazard_a(3'd4);
      cyc(E_STL, E_STL);
      idle();
      cyc(E_RUN, E_STL); cyc(E_RUN, E_STL);
    end
    cyc(E_RUN, E_RUN);
`ifdef PIPE_PERF_CNT_EN
    chk_eq("dut1_flush_count", o1_flc, 16'd3);
    chk_eq("dut1_stall_cycles", o1_stc, 16'd2);
    chk_eq("dut2_flush_count", o2_flc, 16'd3);
    chk_eq("dut2_stall_cycles", o2_stc, 16'd6);
`endif

    @(negedge clk); #1;
    chk_eq("sb_drain", 16'(sb_q.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
